// File: rtl/vga_timing_pkg.sv
// Shared timing constants and types for the VGA pixel-timing generator.
// The defaults describe 640x480@60 with a 25 MHz pixel clock.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  // Largest axis length that a coord_t can address.
  localparam int COORD_LIMIT = 1024;

  function automatic int axis_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

endpackage

// File: rtl/vga_timing_if.sv
// Scan-position and sync bundle from the timing generator to the renderers.
interface vga_timing_if;

  logic                   hs;
  logic                   vs;
  logic                   blank;
  vga_timing_pkg::coord_t DrawX;
  vga_timing_pkg::coord_t DrawY;
  logic                   line_start;
  logic                   frame_start;
  logic [15:0]            frame_count;

  modport master (
    output hs, vs, blank, DrawX, DrawY, line_start, frame_start, frame_count
  );

  modport slave (
    input hs, vs, blank, DrawX, DrawY, line_start, frame_start, frame_count
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One scan axis: a wrapping position counter plus its visible and sync decodes.
// Decodes are taken from the next count so they line up with the registered count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   VISIBLE  = 640,
  parameter int   FRONT    = 16,
  parameter int   SYNC     = 96,
  parameter int   BACK     = 48,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic   vga_clk,
  input  logic   reset,
  input  logic   advance,
  output coord_t count,
  output logic   wrap,
  output logic   active,
  output logic   sync
);

  localparam int TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);

  // One extra bit so a sync window ending exactly at 1024 still compares correctly.
  localparam logic [10:0] LAST       = 11'(TOTAL - 1);
  localparam logic [10:0] VIS_END    = 11'(VISIBLE);
  localparam logic [10:0] SYNC_BEGIN = 11'(VISIBLE + FRONT);
  localparam logic [10:0] SYNC_END   = 11'(VISIBLE + FRONT + SYNC);

  coord_t      count_nxt;
  logic [10:0] nxt_ext;
  logic        sync_nxt;

  assign wrap = advance && ({1'b0, count} == LAST);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    count_nxt = count;
    if (wrap) begin
      count_nxt = '0;
    end else if (advance) begin
      count_nxt = count + 1'b1;
    end
  end

  assign nxt_ext  = {1'b0, count_nxt};
  assign sync_nxt = (nxt_ext >= SYNC_BEGIN) && (nxt_ext < SYNC_END);

  // active is combinational: it describes the position the count moves to on this edge.
  assign active = nxt_ext < VIS_END;

  // NOTE: state is updated with non-blocking assignments only.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      count <= coord_t'(TOTAL - 1);
      sync  <= ~SYNC_POL;
    end else begin
      count <= count_nxt;
      sync  <= sync_nxt ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA pixel-timing master: scan position, display enable, sync pulses
// and frame/line markers, all registered and describing the same pixel.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int   H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int   H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int   H_BACK    = vga_timing_pkg::H_BACK,
  parameter int   V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int   V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int   V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int   V_BACK    = vga_timing_pkg::V_BACK,
  parameter logic SYNC_POL  = 1'b0
) (
  input logic          vga_clk,
  input logic          reset,
  vga_timing_if.master vga
);

  localparam int H_LEN = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_LEN = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  if (H_LEN > COORD_LIMIT || V_LEN > COORD_LIMIT) begin : g_bad_geometry
    $error("vga_timing_gen: H_TOTAL=%0d / V_TOTAL=%0d exceed %0d", H_LEN, V_LEN, COORD_LIMIT);
  end

  coord_t      h_count, v_count;
  logic        h_wrap, v_wrap;
  logic        h_active, v_active;
  logic        h_sync, v_sync;
  logic        blank_q, line_start_q, frame_start_q;
  logic [15:0] frame_count_q;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK),
    .SYNC_POL(SYNC_POL)
  ) u_h_axis (
    .vga_clk(vga_clk),
    .reset  (reset),
    .advance(1'b1),
    .count  (h_count),
    .wrap   (h_wrap),
    .active (h_active),
    .sync   (h_sync)
  );

  // The vertical axis steps on the same edge that the line counter returns to 0,
  // so v_wrap marks the edge that lands on (0,0).
  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK),
    .SYNC_POL(SYNC_POL)
  ) u_v_axis (
    .vga_clk(vga_clk),
    .reset  (reset),
    .advance(h_wrap),
    .count  (v_count),
    .wrap   (v_wrap),
    .active (v_active),
    .sync   (v_sync)
  );

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      blank_q       <= h_active && v_active;
      line_start_q  <= h_wrap;
      frame_start_q <= v_wrap;
      if (v_wrap) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  assign vga.hs          = h_sync;
  assign vga.vs          = v_sync;
  assign vga.blank       = blank_q;
  assign vga.DrawX       = h_count;
  assign vga.DrawY       = v_count;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a cycle-index reference model pushes the expected pixel state
// for every clock edge; a negedge monitor pops and compares it against three builds.
module tb_vga_timing_gen;

  typedef struct packed {
    int   hv, hf, hs, hb;
    int   vv, vf, vs, vb;
    logic pol;
  } geom_t;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } exp_t;

  localparam geom_t G_DEF   = '{hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33, pol:1'b0};
  localparam geom_t G_SMALL = '{hv:16, hf:3, hs:4, hb:5, vv:6, vf:2, vs:2, vb:3, pol:1'b0};
  localparam geom_t G_POL   = '{hv:16, hf:3, hs:4, hb:5, vv:6, vf:2, vs:2, vb:3, pol:1'b1};

  bit   clk = 1'b0;
  logic reset = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t q_def[$];
  exp_t q_small[$];
  exp_t q_pol[$];

  vga_timing_if def_if();
  vga_timing_if small_if();
  vga_timing_if pol_if();

  always #5 clk = ~clk;

  vga_timing_gen dut_def (
    .vga_clk(clk),
    .reset  (reset),
    .vga    (def_if)
  );

  vga_timing_gen #(
    .H_VISIBLE(G_SMALL.hv), .H_FRONT(G_SMALL.hf), .H_SYNC(G_SMALL.hs), .H_BACK(G_SMALL.hb),
    .V_VISIBLE(G_SMALL.vv), .V_FRONT(G_SMALL.vf), .V_SYNC(G_SMALL.vs), .V_BACK(G_SMALL.vb),
    .SYNC_POL (G_SMALL.pol)
  ) dut_small (
    .vga_clk(clk),
    .reset  (reset),
    .vga    (small_if)
  );

  vga_timing_gen #(
    .H_VISIBLE(G_POL.hv), .H_FRONT(G_POL.hf), .H_SYNC(G_POL.hs), .H_BACK(G_POL.hb),
    .V_VISIBLE(G_POL.vv), .V_FRONT(G_POL.vf), .V_SYNC(G_POL.vs), .V_BACK(G_POL.vb),
    .SYNC_POL (G_POL.pol)
  ) dut_pol (
    .vga_clk(clk),
    .reset  (reset),
    .vga    (pol_if)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  // Expected state after the n-th free-running edge since reset release (n = 0 is (0,0)).
  function automatic exp_t model(input geom_t g, input bit rst, input int n);
    exp_t e;
    int   ht = g.hv + g.hf + g.hs + g.hb;
    int   vt = g.vv + g.vf + g.vs + g.vb;
    int   x  = n % ht;
    int   y  = (n / ht) % vt;
    int   fr = n / (ht * vt);
    if (rst) begin
      e.x     = 10'(ht - 1);
      e.y     = 10'(vt - 1);
      e.blank = 1'b0;
      e.hs    = ~g.pol;
      e.vs    = ~g.pol;
      e.ls    = 1'b0;
      e.fs    = 1'b0;
      e.fc    = 16'd0;
    end else begin
      e.x     = 10'(x);
      e.y     = 10'(y);
      e.blank = (x < g.hv) && (y < g.vv);
      e.hs    = (x >= g.hv + g.hf && x < g.hv + g.hf + g.hs) ? g.pol : ~g.pol;
      e.vs    = (y >= g.vv + g.vf && y < g.vv + g.vf + g.vs) ? g.pol : ~g.pol;
      e.ls    = (x == 0);
      e.fs    = (x == 0) && (y == 0);
      e.fc    = 16'(fr + 1);
    end
    return e;
  endfunction

  task automatic compare(input string who, input exp_t got, input exp_t exp);
    check({who, ".DrawX"},       32'(got.x),     32'(exp.x));
    check({who, ".DrawY"},       32'(got.y),     32'(exp.y));
    check({who, ".blank"},       32'(got.blank), 32'(exp.blank));
    check({who, ".hs"},          32'(got.hs),    32'(exp.hs));
    check({who, ".vs"},          32'(got.vs),    32'(exp.vs));
    check({who, ".line_start"},  32'(got.ls),    32'(exp.ls));
    check({who, ".frame_start"}, 32'(got.fs),    32'(exp.fs));
    check({who, ".frame_count"}, 32'(got.fc),    32'(exp.fc));
  endtask

  function automatic exp_t sample(input logic [9:0] x, input logic [9:0] y,
                                  input logic b, input logic h, input logic v,
                                  input logic l, input logic f, input logic [15:0] c);
    return {x, y, b, h, v, l, f, c};
  endfunction

  always @(negedge clk) begin
    if (q_def.size() > 0) begin
      compare("def", sample(def_if.DrawX, def_if.DrawY, def_if.blank, def_if.hs, def_if.vs,
                            def_if.line_start, def_if.frame_start, def_if.frame_count),
              q_def.pop_front());
    end
    if (q_small.size() > 0) begin
      compare("small", sample(small_if.DrawX, small_if.DrawY, small_if.blank, small_if.hs,
                              small_if.vs, small_if.line_start, small_if.frame_start,
                              small_if.frame_count),
              q_small.pop_front());
    end
    if (q_pol.size() > 0) begin
      compare("pol", sample(pol_if.DrawX, pol_if.DrawY, pol_if.blank, pol_if.hs, pol_if.vs,
                            pol_if.line_start, pol_if.frame_start, pol_if.frame_count),
              q_pol.pop_front());
    end
  end

  int n_edge = 0;

  // Drive reset for the coming edge and queue what every build must show after it.
  task automatic drive(input bit rst, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      reset = rst;
      q_def.push_back(model(G_DEF, rst, n_edge));
      q_small.push_back(model(G_SMALL, rst, n_edge));
      q_pol.push_back(model(G_POL, rst, n_edge));
      n_edge = rst ? 0 : n_edge + 1;
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    drive(1'b1, 3);
    // Two and a half default lines: covers 639/640, 655/656, 751/752 and several
    // whole frames of the reduced geometries.
    drive(1'b0, 2000);
    // Mid-frame reset and release.
    drive(1'b1, 2);
    drive(1'b0, 1200);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(q_def.size() + q_small.size() + q_pol.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
